// File: rtl/ascii_time_cmd_parser_pkg.sv
// Shared constants, field widths and FSM encoding
// for the ASCII time-set frame parser.
package ascii_time_cmd_parser_pkg;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_T     = 8'h54;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;
   localparam int TMO_W  = 27;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_H10,
      ST_H1,
      ST_C1,
      ST_M10,
      ST_M1,
      ST_C2,
      ST_S10,
      ST_S1,
      ST_EOL
   } state_t;

endpackage

// File: rtl/ascii_digit_check.sv
// Decimal ASCII digit check: flags bytes '0'..('0'+max_digit)
// and returns the binary digit value.
module ascii_digit_check
   import ascii_time_cmd_parser_pkg::*;
(
   input  logic [7:0] data,
   input  logic [3:0] max_digit,
   output logic       is_ok,
   output logic [3:0] value
);

   logic [7:0] diff;

   // Bytes below '0' wrap to a large difference and fail the upper-nibble test
   always_comb begin
      diff  = data - ASCII_0;
      value = diff[3:0];
      is_ok = (diff[7:4] == 4'd0) && (diff[3:0] <= max_digit);
   end

endmodule

// File: rtl/ascii_time_cmd_parser.sv
// Parses "THH:MM:SS<CR|LF>" frames from UART RX into binary time,
// with a load strobe on success and an error strobe on reject/timeout.
module ascii_time_cmd_parser
   import ascii_time_cmd_parser_pkg::*;
#(
   parameter logic [7:0]  HDR_CHAR    = ASCII_T,
   parameter logic [7:0]  SEP_CHAR    = ASCII_COLON,
   parameter logic [7:0]  EOL_CHAR    = ASCII_CR,
   parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_done,
   output logic [HOUR_W-1:0] o_hour,
   output logic [MIN_W-1:0]  o_min,
   output logic [SEC_W-1:0]  o_sec,
   output logic              o_set_valid,
   output logic              o_frame_err,
   output logic              o_busy
);

   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);

   state_t            state, nxt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [3:0]        tens;
   logic [HOUR_W-1:0] hour_s;
   logic [MIN_W-1:0]  min_s;
   logic [SEC_W-1:0]  sec_s;

   logic [3:0] max_d;
   logic       dig_ok;
   logic [3:0] dig_val;
   logic [5:0] fld;
   logic       acc, rej, tmo;
   logic       ld_tens, ld_h, ld_m, ld_s;

   ascii_digit_check u_dig (
      .data      (i_rx_data),
      .max_digit (max_d),
      .is_ok     (dig_ok),
      .value     (dig_val)
   );

   // Next-state, per-byte accept/reject decisions and scratch load enables
   always_comb begin
      nxt     = state;
      acc     = 1'b0;
      rej     = 1'b0;
      tmo     = 1'b0;
      ld_tens = 1'b0;
      ld_h    = 1'b0;
      ld_m    = 1'b0;
      ld_s    = 1'b0;
      max_d   = 4'd9;
      fld     = 6'({3'd0, tens} * 7'd10 + {3'd0, dig_val});
      unique case (state)
         ST_H10:          max_d = 4'd2;
         ST_H1:           max_d = (tens == 4'd2) ? 4'd3 : 4'd9;
         ST_M10, ST_S10:  max_d = 4'd5;
         default:         max_d = 4'd9;
      endcase
      if (i_rx_done) begin
         unique case (state)
            ST_IDLE: if (i_rx_data == HDR_CHAR) nxt = ST_H10;
            ST_H10:  if (dig_ok) begin nxt = ST_H1; ld_tens = 1'b1; end
                     else rej = 1'b1;
            ST_H1:   if (dig_ok) begin nxt = ST_C1; ld_h = 1'b1; end
                     else rej = 1'b1;
            ST_C1:   if (i_rx_data == SEP_CHAR) nxt = ST_M10;
                     else rej = 1'b1;
            ST_M10:  if (dig_ok) begin nxt = ST_M1; ld_tens = 1'b1; end
                     else rej = 1'b1;
            ST_M1:   if (dig_ok) begin nxt = ST_C2; ld_m = 1'b1; end
                     else rej = 1'b1;
            ST_C2:   if (i_rx_data == SEP_CHAR) nxt = ST_S10;
                     else rej = 1'b1;
            ST_S10:  if (dig_ok) begin nxt = ST_S1; ld_tens = 1'b1; end
                     else rej = 1'b1;
            ST_S1:   if (dig_ok) begin nxt = ST_EOL; ld_s = 1'b1; end
                     else rej = 1'b1;
            ST_EOL:  if (i_rx_data == EOL_CHAR || i_rx_data == ASCII_LF) begin
                        nxt = ST_IDLE;
                        acc = 1'b1;
                     end else rej = 1'b1;
            default: nxt = ST_IDLE;
         endcase
         if (rej) nxt = (i_rx_data == HDR_CHAR) ? ST_H10 : ST_IDLE;
      end else if (state != ST_IDLE && tmo_cnt == TMO_MAX) begin
         tmo = 1'b1;
         nxt = ST_IDLE;
      end
   end

   // State, timeout counter, scratch fields and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         tmo_cnt     <= '0;
         tens        <= '0;
         hour_s      <= '0;
         min_s       <= '0;
         sec_s       <= '0;
         o_hour      <= '0;
         o_min       <= '0;
         o_sec       <= '0;
         o_set_valid <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         state <= nxt;
         if (i_rx_done || tmo || state == ST_IDLE) tmo_cnt <= '0;
         else                                       tmo_cnt <= tmo_cnt + 1'b1;
         if (ld_tens) tens   <= dig_val;
         if (ld_h)    hour_s <= fld[HOUR_W-1:0];
         if (ld_m)    min_s  <= fld[MIN_W-1:0];
         if (ld_s)    sec_s  <= fld[SEC_W-1:0];
         if (acc) begin
            o_hour <= hour_s;
            o_min  <= min_s;
            o_sec  <= sec_s;
         end
         o_set_valid <= acc;
         o_frame_err <= rej | tmo;
      end
   end

   assign o_busy = (state != ST_IDLE);

endmodule
